reg_status_file: RTL

- Architectural register file plus per-register rename status; sits directly downstream of the reorder buffer.
- Consumes the ROB commit broadcast (rd index, ROB tag, value) to retire results into x1..x31.
- Records the producing ROB tag for each destination at dispatch.
- Serves two operand lookups to dispatch, returning either a committed value or the ROB tag the operand still waits on.

---
 rtl/reg_status_file_pkg.sv | 19 +
 rtl/reg_status_lookup.sv | 47 ++++
 rtl/reg_status_file.sv | 125 ++++++++++++
 3 files changed

// File: rtl/reg_status_file_pkg.sv
// Shared widths and constants for the architectural register/status file.
// Optional macro REG_STATUS_BYPASS_EN enables same-cycle commit forwarding in lookups.
package reg_status_file_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_TAG_W   = 4;
  localparam int DEF_REG_NUM = 32;
  localparam int IDX_W       = 5;

  // 2**DEF_TAG_W must exceed ROB_SIZE so that tag 0 is never a live ROB entry.
  localparam int ROB_SIZE    = 8;

  localparam logic [DEF_TAG_W-1:0] NO_TAG = '0;

  function automatic logic tag_pending(input logic [DEF_TAG_W-1:0] tag);
    return tag != NO_TAG;
  endfunction

endpackage

// File: rtl/reg_status_lookup.sv
// Combinational operand read port: committed value plus pending producer tag.
// With REG_STATUS_BYPASS_EN defined, a same-cycle matching commit is forwarded.
module reg_status_lookup
  import reg_status_file_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int REG_NUM = DEF_REG_NUM
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic [XLEN-1:0]  i_values [REG_NUM],
  input  logic [TAG_W-1:0] i_tags   [REG_NUM],
  input  logic             i_cdb_active,
  input  logic [IDX_W-1:0] i_cdb_rd_idx,
  input  logic [TAG_W-1:0] i_cdb_tag,
  input  logic [XLEN-1:0]  i_cdb_val,
  output logic [XLEN-1:0]  o_val,
  output logic [TAG_W-1:0] o_tag
);

`ifdef REG_STATUS_BYPASS_EN
  logic w_fwd;

  // Only the commit of the producer we still wait on may be forwarded.
  assign w_fwd = i_cdb_active && (i_idx == i_cdb_rd_idx) && (i_idx != '0)
                 && (i_tags[i_idx] == i_cdb_tag);

  always_comb begin
    o_val = i_values[i_idx];
    o_tag = i_tags[i_idx];
    if (w_fwd) begin
      o_val = i_cdb_val;
      o_tag = TAG_W'(NO_TAG);
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{i_cdb_active, i_cdb_rd_idx, i_cdb_tag, i_cdb_val};

  always_comb begin
    o_val = i_values[i_idx];
    o_tag = i_tags[i_idx];
  end
`endif

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename tags, fed by ROB commits.
// Build option: REG_STATUS_BYPASS_EN (same-cycle commit forwarding on both lookups).
module reg_status_file
  import reg_status_file_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int REG_NUM = DEF_REG_NUM
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rename_valid,
  input  logic [IDX_W-1:0] rename_rd_idx,
  input  logic [TAG_W-1:0] rename_tag,
  input  logic [IDX_W-1:0] rs1_idx,
  input  logic [IDX_W-1:0] rs2_idx,
  output logic [XLEN-1:0]  rs1_val,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [XLEN-1:0]  rs2_val,
  output logic [TAG_W-1:0] rs2_tag,
  input  logic             cdb_active,
  input  logic [IDX_W-1:0] cdb_rd_idx,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_val,
  input  logic             predict_fail,
  output logic [31:0]      commit_count
);

  logic [XLEN-1:0]  w_values [REG_NUM];
  logic [TAG_W-1:0] w_tags   [REG_NUM];
  logic             w_commit_en;
  logic             w_rename_en;
  logic             w_flush;
  logic [31:0]      r_commit_count;

  assign w_commit_en = rdy_in & cdb_active;
  // A flush discards the instruction being dispatched alongside it.
  assign w_rename_en = rdy_in & rename_valid & ~predict_fail;
  assign w_flush     = rdy_in & predict_fail;

  generate
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_values[gi] = '0;
        assign w_tags[gi]   = '0;
      end else begin : g_live
        logic [XLEN-1:0]  r_value;
        logic [TAG_W-1:0] r_tag;
        logic             w_commit_hit;
        logic             w_rename_hit;

        assign w_commit_hit = w_commit_en && (cdb_rd_idx == IDX_W'(gi));
        assign w_rename_hit = w_rename_en && (rename_rd_idx == IDX_W'(gi));

        always_ff @(posedge clk_in or negedge rst_in) begin
          if (!rst_in) begin
            r_value <= '0;
          end else if (w_commit_hit) begin
            r_value <= cdb_val;
          end
        end

        // Priority: flush, then rename, then clear only if this commit is the latest producer.
        always_ff @(posedge clk_in or negedge rst_in) begin
          if (!rst_in) begin
            r_tag <= TAG_W'(NO_TAG);
          end else if (w_flush) begin
            r_tag <= TAG_W'(NO_TAG);
          end else if (w_rename_hit) begin
            r_tag <= rename_tag;
          end else if (w_commit_hit && (r_tag == cdb_tag)) begin
            r_tag <= TAG_W'(NO_TAG);
          end
        end

        assign w_values[gi] = r_value;
        assign w_tags[gi]   = r_tag;
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_commit_count <= '0;
    end else if (w_commit_en) begin
      r_commit_count <= r_commit_count + 32'd1;
    end
  end

  assign commit_count = r_commit_count;

  reg_status_lookup #(
    .XLEN    (XLEN),
    .TAG_W   (TAG_W),
    .REG_NUM (REG_NUM)
  ) u_lookup_rs1 (
    .i_idx        (rs1_idx),
    .i_values     (w_values),
    .i_tags       (w_tags),
    .i_cdb_active (cdb_active),
    .i_cdb_rd_idx (cdb_rd_idx),
    .i_cdb_tag    (cdb_tag),
    .i_cdb_val    (cdb_val),
    .o_val        (rs1_val),
    .o_tag        (rs1_tag)
  );

  reg_status_lookup #(
    .XLEN    (XLEN),
    .TAG_W   (TAG_W),
    .REG_NUM (REG_NUM)
  ) u_lookup_rs2 (
    .i_idx        (rs2_idx),
    .i_values     (w_values),
    .i_tags       (w_tags),
    .i_cdb_active (cdb_active),
    .i_cdb_rd_idx (cdb_rd_idx),
    .i_cdb_tag    (cdb_tag),
    .i_cdb_val    (cdb_val),
    .o_val        (rs2_val),
    .o_tag        (rs2_tag)
  );

endmodule
